// File: rtl/tx_shift_ctrl_if.sv
// Byte-source / bit-sink bundle of the Tx shift controller.
// The controller takes the slave side; the byte source and bit consumer sit on the master side.
interface tx_shift_ctrl_if;
    logic       Tx_Bit_En;
    logic       Tx_Abort;
    logic [7:0] Tx_Data_In;
    logic       Tx_Data_Valid;
    logic       Tx_Data_Last;
    logic       Tx_Data_Ready;
    logic       Tx_Bit;
    logic       Tx_Bit_Valid;
    logic       Tx_Stuff;
    logic       Tx_Active;
    logic       Tx_Done;
    logic       Tx_Underrun;

    modport master (
        output Tx_Bit_En, Tx_Abort, Tx_Data_In, Tx_Data_Valid, Tx_Data_Last,
        input  Tx_Data_Ready, Tx_Bit, Tx_Bit_Valid, Tx_Stuff, Tx_Active, Tx_Done, Tx_Underrun
    );

    modport slave (
        input  Tx_Bit_En, Tx_Abort, Tx_Data_In, Tx_Data_Valid, Tx_Data_Last,
        output Tx_Data_Ready, Tx_Bit, Tx_Bit_Valid, Tx_Stuff, Tx_Active, Tx_Done, Tx_Underrun
    );
endinterface

// File: rtl/tx_shift_ctrl.sv
// Tx sequencer: one-entry hold buffer feeding an LSB-first shifter with USB-style bit stuffing.
// Bytes chain back-to-back within a packet; completion is flagged by Done, starvation by Underrun.
module tx_shift_ctrl #(
    parameter bit          STUFF_EN  = 1'b1,
    parameter int unsigned STUFF_RUN = 6
) (
    input logic         Tx_Shift_Ctrl_Clk,
    input logic         Tx_Shift_Ctrl_Rst,
    tx_shift_ctrl_if.slave tx
);
    typedef enum logic [1:0] {StIdle, StLoad, StShift, StFinish} state_e;

    localparam logic [2:0] RunLen = 3'(STUFF_RUN);

    state_e     state_q;
    logic [8:0] hold_q;
    logic       hold_full_q;
    logic [7:0] shifter_q;
    logic       cur_last_q;
    logic [3:0] bit_cnt_q;
    logic [2:0] ones_cnt_q;
    logic       bit_q;
    logic       bit_valid_q;
    logic       stuff_q;
    logic       done_q;
    logic       underrun_q;

    logic       accept;
    logic       stuff_now;
    logic [2:0] ones_next;

    assign accept    = tx.Tx_Data_Valid && !hold_full_q;
    assign stuff_now = STUFF_EN && (ones_cnt_q == RunLen);
    assign ones_next = shifter_q[0] ? ones_cnt_q + 3'd1 : 3'd0;

    always_ff @(posedge Tx_Shift_Ctrl_Clk) begin
        if (Tx_Shift_Ctrl_Rst || tx.Tx_Abort) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shifter_q   <= '0;
            cur_last_q  <= 1'b0;
            bit_cnt_q   <= '0;
            ones_cnt_q  <= '0;
            bit_q       <= 1'b1;
            bit_valid_q <= 1'b0;
            stuff_q     <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            bit_valid_q <= 1'b0;
            stuff_q     <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;

            // Accept needs an empty hold and every emptying path needs a full one, so they
            // never collide on the same edge.
            if (accept) begin
                hold_q      <= {tx.Tx_Data_Last, tx.Tx_Data_In};
                hold_full_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (hold_full_q) state_q <= StLoad;
                end
                StLoad: begin
                    shifter_q   <= hold_q[7:0];
                    cur_last_q  <= hold_q[8];
                    hold_full_q <= 1'b0;
                    bit_cnt_q   <= '0;
                    state_q     <= StShift;
                end
                StShift: begin
                    if (tx.Tx_Bit_En) begin
                        bit_valid_q <= 1'b1;
                        if (stuff_now) begin
                            bit_q      <= 1'b0;
                            stuff_q    <= 1'b1;
                            ones_cnt_q <= '0;
                            // bit_cnt of 8 only survives when a trailing stuff was owed
                            if (bit_cnt_q == 4'd8) state_q <= StFinish;
                        end else begin
                            bit_q      <= shifter_q[0];
                            shifter_q  <= {1'b0, shifter_q[7:1]};
                            bit_cnt_q  <= bit_cnt_q + 4'd1;
                            ones_cnt_q <= ones_next;
                            if (bit_cnt_q == 4'd7) begin
                                if (!cur_last_q) begin
                                    if (hold_full_q) begin
                                        shifter_q   <= hold_q[7:0];
                                        cur_last_q  <= hold_q[8];
                                        hold_full_q <= 1'b0;
                                        bit_cnt_q   <= '0;
                                    end else begin
                                        underrun_q <= 1'b1;
                                        ones_cnt_q <= '0;
                                        state_q    <= StIdle;
                                    end
                                end else if (!(STUFF_EN && ones_next == RunLen)) begin
                                    state_q <= StFinish;
                                end
                            end
                        end
                    end
                end
                StFinish: begin
                    done_q     <= 1'b1;
                    ones_cnt_q <= '0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx.Tx_Data_Ready = ~hold_full_q;
    assign tx.Tx_Bit        = bit_q;
    assign tx.Tx_Bit_Valid  = bit_valid_q;
    assign tx.Tx_Stuff      = stuff_q;
    assign tx.Tx_Active     = (state_q != StIdle);
    assign tx.Tx_Done       = done_q;
    assign tx.Tx_Underrun   = underrun_q;
endmodule

// File: doc/tx_shift_ctrl.md
Name: tx_shift_ctrl

Overview:
Transmit sequencer that owns the Tx hold register and the serialising shifter. It accepts bytes over a valid/ready handshake into a one-entry hold buffer. It moves each byte into the shifter without gaps and emits NRZ bits LSB-first, one per bit strobe, with USB bit stuffing. It sits between the packet/byte source and the NRZI encoder, and signals packet completion or underrun.

Parameters:
STUFF_EN, 1, 1 enables bit stuffing; 0 passes data bits only.
STUFF_RUN, 6, number of consecutive emitted 1s after which a stuffed 0 is inserted (range 2..7).

Ports:
Tx_Shift_Ctrl_Clk  input  1  single clock; all state changes on rising edge.
Tx_Shift_Ctrl_Rst  input  1  synchronous, active-high reset.
Tx_Bit_En  input  1  one-cycle bit-time strobe; gaps of any length are allowed.
Tx_Abort  input  1  synchronous abort; same effect as reset on datapath and FSM.
Tx_Data_In  input  8  byte to send.
Tx_Data_Valid  input  1  source has a byte.
Tx_Data_Last  input  1  qualifies Tx_Data_In as final byte of packet.
Tx_Data_Ready  output  1  hold buffer empty; equals ~hold_full (combinational from flag).
Tx_Bit  output  1  current NRZ bit, registered, held between strobes.
Tx_Bit_Valid  output  1  one-cycle pulse: new bit on Tx_Bit.
Tx_Stuff  output  1  high with Tx_Bit_Valid when the bit is a stuffed 0.
Tx_Active  output  1  packet in progress (LOAD/SHIFT/FINISH).
Tx_Done  output  1  one-cycle pulse: packet finished normally.
Tx_Underrun  output  1  one-cycle pulse: shifter drained, hold empty, last not seen.

Behaviour:
- Reset/abort values: state IDLE, hold_full=0, bit_cnt=0, ones_cnt=0, Tx_Bit=1, Tx_Bit_Valid=0, Tx_Stuff=0, Tx_Active=0, Tx_Done=0, Tx_Underrun=0. Mid-packet reset or abort discards hold and shifter contents; no Done or Underrun pulse. Reset has priority over abort, and abort has priority over all other events.
- Accept: on an edge with Tx_Data_Valid & Tx_Data_Ready, hold <= {Last, Data} and hold_full <= 1. A byte is never accepted in the same edge the hold empties, so Ready rises one cycle after the shifter takes the byte.
- FSM states: IDLE, LOAD, SHIFT, FINISH.
- IDLE: when hold_full=1, go to LOAD.
- LOAD (1 cycle): shifter <= hold, cur_last <= hold.last, hold_full <= 0, bit_cnt <= 0, then go to SHIFT. Tx_Active=1 from LOAD onward.
- SHIFT: act only on edges with Tx_Bit_En=1.
  - If STUFF_EN and ones_cnt==STUFF_RUN: Tx_Bit<=0, Tx_Stuff<=1, ones_cnt<=0. The shifter and bit_cnt do not advance.
  - Otherwise: Tx_Bit<=shifter[0], shift right, bit_cnt++. ones_cnt <= shifter[0] ? ones_cnt+1 : 0.
  - Tx_Bit_Valid pulses the cycle after every such edge.
- End of byte (edge emitting data bit 8):
  - cur_last=0 and hold_full=1: shifter <= hold in the same edge (no idle bit time), hold_full <= 0, bit_cnt <= 0.
  - cur_last=0 and hold_full=0: Tx_Underrun pulse, go to IDLE, ones_cnt <= 0.
  - cur_last=1: if the stuff condition is pending (ones_cnt will equal STUFF_RUN), stay in SHIFT and emit the trailing stuffed 0 on the next strobe, then go to FINISH. Otherwise go to FINISH.
- FINISH (1 cycle): Tx_Done=1, ones_cnt <= 0, go to IDLE. Tx_Active drops when IDLE is entered.
- The ones_cnt run carries across byte boundaries within a packet.
- Tx_Data_Ready may be high during SHIFT, so a byte for the next packet can be held while the current packet finishes. It starts via IDLE->LOAD after FINISH.

Test Plan:
- Single byte: 0xA5 with Last, Bit_En every 4 cycles -> Valid bits 1,0,1,0,0,1,0,1, Stuff never high, Done one cycle after the 8th Valid, Active low afterwards.
- Stuff mid-stream: 0xFF then 0x00 with Last -> 1×6, stuffed 0 (Stuff=1), 1,1, then 0×8. That is 17 Valid pulses, contiguous at strobe rate with no gap at the byte boundary.
- Trailing stuff: 0xFC with Last -> 0,0,1×6, then stuffed 0, for 9 Valid pulses, then Done.
- Underrun: 0x12 without Last and no further Valid -> 8 bits, then an Underrun pulse instead of Done, and IDLE.
- Abort at bit 3 of 0x55 with the next byte in hold -> no further Valid, Ready=1 next cycle, Tx_Bit=1, no Done or Underrun pulse.
- STUFF_EN=0 with 0xFF and Last, plus reset asserted during LOAD of a second packet -> 8 ones with no stuff bit, then all outputs at reset values.
